pal_regarray: RTL and testbench
===============================

// Module: pal_regarray
// PURPOSE
//  Parametrised registered PAL/GAL emulation core, successor to the fixed 8-in/8-out pal16r8.
//  AND-OR array with a serially loaded fuse map. Each output is configurable as registered or
//  combinational, with selectable polarity. Sits between the PAL socket pins and the fuse loader.
// PARAMETERS
//  N_IN   8  dedicated input pins
//  N_OUT  8  output macrocells (each also fed back into the array)
//  N_PT   8  product terms per output
//  Derived: L = 2*(N_IN+N_OUT) literals per PT; S = N_PT*L+2 fuses per output; FUSES = N_OUT*S (2064 default)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  i           in   N_IN   input pins
//  o           out  N_OUT  output pins
//  prog_en     in   1      rising edge starts a fuse load; must stay high for the whole load
//  prog_valid  in   1      prog_din is valid this cycle
//  prog_din    in   1      fuse bit, index order 0..FUSES-1
//  prog_busy   out  1      high in LOAD
//  prog_done   out  1      high in RUN
//  prog_err    out  1      load aborted; sticky until the next prog_en rise
//  prog_dout   out  1      present only with PAL_FUSE_READBACK_EN
// BEHAVIOUR
//  Fuse index: out*S + pt*L + lit. lit 2k = true and lit 2k+1 = complement of signal k.
//   Signals 0..N_IN-1 are i; signals N_IN.. are output feedback.
//   out*S+N_PT*L = mode (1 = registered, 0 = combinational); out*S+N_PT*L+1 = polarity (1 = invert).
//  Fuse = 1 means intact: the literal participates in the AND. A PT with any true/complement pair
//   intact evaluates 0. sum = OR of the N_PT terms; val = sum ^ polarity.
//  Registered output: Q <= val on each clk edge in RUN; o = Q; feedback = Q.
//  Combinational output: o = val in the same cycle. Feedback = shadow flop of last cycle's o,
//   so no combinational loops exist. The shadow flop is updated every clk in RUN.
//  Reset (async):
//   - all fuses = 1; Q and shadow flops = 0; o = 0;
//   - prog_busy/prog_done/prog_err = 0; prog_dout = 0; FSM in IDLE.
//  FSM:
//   - IDLE: o = 0. prog_en rise -> LOAD; cnt = 0; prog_err cleared.
//   - LOAD: o = 0 and Q held at 0. When prog_valid is high, fuse[cnt] <= prog_din and cnt++.
//     On acceptance of bit FUSES-1 -> RUN on the next cycle.
//     prog_valid low stalls with no timeout.
//     prog_en low before completion -> IDLE with prog_err = 1. The partial fuse map is kept.
//   - RUN: array active. prog_valid is ignored. prog_en must fall and rise again to reload.
//     A prog_en rise in RUN -> LOAD: Q and shadow cleared, o = 0, cnt = 0.
//  prog_en rise with prog_valid in the same cycle: the bit is not accepted;
//   the first bit is taken no earlier than the cycle after entry to LOAD.
//  cnt width = $clog2(FUSES); it never wraps because it saturates to the RUN transition.
//  rst_n low mid-load aborts to IDLE with a blank array; prog_err = 0.
// CONFIGURATION
//  PAL_FUSE_READBACK_EN defined:
//   - port prog_dout exists. On each accepted bit, prog_dout <= old fuse[cnt], registered,
//     so it is valid the cycle after the write. Reloading therefore shifts out the previous map.
//   - prog_dout = 0 outside LOAD.
//  Not defined: no prog_dout port and no readback logic. All other behaviour is identical.
// TESTING (defaults, FUSES = 2064, S = 258, L = 32)
//  1 Reset, no load -> o=8'h00, prog_done=0, prog_busy=0; i sweep 00..FF leaves o=00.
//  2 Load: out0 mode=1, PT0 intact only at lit0 (i[0]), other PTs blank.
//    i=01 -> o[0]=1 after the next clk edge; i=00 -> o[0]=0 one edge later.
//  3 Load: out1 mode=1, PT0 intact only at lit 2*9+1 (~o[1] feedback) -> o[1] toggles 0,1,0,1 each edge.
//  4 Load: out2 mode=0, pol=1, PT0 intact only at lit 4 (i[2]) -> o[2]=~i[2] with no clk edge;
//    feedback for out2 lags one cycle.
//  5 Drop prog_en after 100 bits -> prog_err=1, prog_busy=0, o=00; new prog_en rise clears prog_err.
//  6 rst_n low at bit 500 -> o=00, prog_done=0, array blank (repeat test 1).
//    With the macro: reload shows the previous map on prog_dout, one cycle later per bit.

Source files
------------

// File: rtl/pal_regarray.sv
// pal_regarray: parametrised registered PAL/GAL core, AND-OR array with serially loaded fuse map.
// Optional macro PAL_FUSE_READBACK_EN adds prog_dout, which shifts out the old map during a reload.
`default_nettype none

module pal_regarray #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int N_PT  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  i,
  output logic [N_OUT-1:0] o,
  input  logic             prog_en,
  input  logic             prog_valid,
  input  logic             prog_din,
  output logic             prog_busy,
  output logic             prog_done,
  output logic             prog_err
`ifdef PAL_FUSE_READBACK_EN
  ,
  output logic             prog_dout
`endif
);

  localparam int NSIG  = N_IN + N_OUT;
  localparam int L     = 2 * NSIG;
  localparam int S     = N_PT * L + 2;
  localparam int FUSES = N_OUT * S;
  localparam int CW    = $clog2(FUSES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             en_q;
  logic [FUSES-1:0] fuse_q;
  logic [N_OUT-1:0] q_q, q_d;

  logic             en_rise;
  logic             accept;
  logic [NSIG-1:0]  sig_w;
  logic [N_OUT-1:0] mode_w, pol_w, sum_w, val_w;
  logic             term;

  assign en_rise = prog_en & ~en_q;

  // One flop per output serves both as the registered Q and as the
  // combinational shadow: each captures val every RUN cycle.
  assign sig_w = {q_q, i};

  for (genvar g = 0; g < N_OUT; g++) begin : g_cfg
    assign mode_w[g] = fuse_q[g*S + N_PT*L];
    assign pol_w[g]  = fuse_q[g*S + N_PT*L + 1];
  end

  always_comb begin
    sum_w = '0;
    term  = 1'b0;
    for (int ob = 0; ob < N_OUT; ob++) begin
      for (int p = 0; p < N_PT; p++) begin
        term = 1'b1;
        for (int k = 0; k < NSIG; k++) begin
          if (fuse_q[ob*S + p*L + 2*k] && !sig_w[k]) term = 1'b0;
          if (fuse_q[ob*S + p*L + 2*k + 1] && sig_w[k]) term = 1'b0;
        end
        sum_w[ob] = sum_w[ob] | term;
      end
    end
  end

  assign val_w = sum_w ^ pol_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!prog_en) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (prog_valid) begin
          accept = 1'b1;
          if (cnt_q == CW'(FUSES - 1)) state_d = ST_RUN;
          else                         cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (en_rise) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign q_d = (state_q == ST_RUN && state_d == ST_RUN) ? val_w : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      en_q    <= prog_en;
      q_q     <= q_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fuse_q <= '1;
    else if (accept) fuse_q[cnt_q] <= prog_din;
  end

`ifdef PAL_FUSE_READBACK_EN
  logic dout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  dout_q <= 1'b0;
    else if (accept)             dout_q <= fuse_q[cnt_q];
    else if (state_q != ST_LOAD) dout_q <= 1'b0;
  end
  assign prog_dout = dout_q;
`endif

  assign o         = (state_q == ST_RUN) ? ((mode_w & q_q) | (~mode_w & val_w)) : '0;
  assign prog_busy = (state_q == ST_LOAD);
  assign prog_done = (state_q == ST_RUN);
  assign prog_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pal_regarray.sv
// tb_pal_regarray: randomized self-checking bench for pal_regarray against a fuse-rule reference model.
`default_nettype none

module tb_pal_regarray;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int NP = 8;
  localparam int L  = 2 * (NI + NO);
  localparam int S  = NP * L + 2;
  localparam int F  = NO * S;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] i;
  logic [NO-1:0] o;
  logic          prog_en, prog_valid, prog_din;
  logic          prog_busy, prog_done, prog_err;
`ifdef PAL_FUSE_READBACK_EN
  logic          prog_dout;
`endif

  pal_regarray #(.N_IN(NI), .N_OUT(NO), .N_PT(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i          (i),
    .o          (o),
    .prog_en    (prog_en),
    .prog_valid (prog_valid),
    .prog_din   (prog_din),
    .prog_busy  (prog_busy),
    .prog_done  (prog_done),
    .prog_err   (prog_err)
`ifdef PAL_FUSE_READBACK_EN
    ,
    .prog_dout  (prog_dout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            mf[F];   // fuses as the DUT should hold them
  bit            nm[F];   // map staged for the next load
  logic [NO-1:0] mq;      // each output's value as of the last clock edge

  function automatic int mode_idx(input int ob);
    return ob*S + NP*L;
  endfunction

  // Sum-of-products from the fuse rules: a PT is the AND of its intact literals.
  function automatic logic [NO-1:0] model_val(input logic [NI-1:0] iv);
    logic [NI+NO-1:0] sg;
    logic [NO-1:0]    r;
    logic             any, term, litv;
    sg = {mq, iv};
    r  = '0;
    for (int ob = 0; ob < NO; ob++) begin
      any = 1'b0;
      for (int p = 0; p < NP; p++) begin
        term = 1'b1;
        for (int lit = 0; lit < L; lit++) begin
          litv = (lit % 2 == 0) ? sg[lit/2] : ~sg[lit/2];
          if (mf[ob*S + p*L + lit]) term = term & litv;
        end
        any = any | term;
      end
      r[ob] = any ^ mf[mode_idx(ob) + 1];
    end
    return r;
  endfunction

  function automatic logic [NO-1:0] model_o(input logic [NI-1:0] iv);
    logic [NO-1:0] v, r;
    v = model_val(iv);
    for (int ob = 0; ob < NO; ob++) r[ob] = mf[mode_idx(ob)] ? mq[ob] : v[ob];
    return r;
  endfunction

  task automatic step_model(input logic [NI-1:0] iv);
    mq = model_val(iv);
  endtask

  task automatic map_blank();
    for (int f = 0; f < F; f++) nm[f] = 1'b1;
    for (int ob = 0; ob < NO; ob++) nm[mode_idx(ob) + 1] = 1'b0;
  endtask

  task automatic map_single(input int ob, input int p, input int lit);
    for (int l = 0; l < L; l++) nm[ob*S + p*L + l] = (l == lit);
  endtask

  task automatic map_random();
    for (int ob = 0; ob < NO; ob++) begin
      for (int f = 0; f < NP*L; f++) nm[ob*S + f] = ($urandom_range(11) == 0);
      nm[mode_idx(ob)]     = 1'($urandom_range(1));
      nm[mode_idx(ob) + 1] = 1'($urandom_range(1));
    end
  endtask

  // Loads the first stop_at bits of nm with random stalls; a junk valid bit
  // accompanies the prog_en rise and must be ignored.
  task automatic load(input int stop_at);
    int n;
    int pend;
    bit pend_old;
    @(posedge clk); #1 prog_en = 1'b0; prog_valid = 1'b0;
    @(posedge clk); #1 prog_en = 1'b1; prog_valid = 1'b1; prog_din = 1'b0;
    @(posedge clk);
    mq = '0;
    n = 0;
    pend = -1;
    pend_old = 1'b0;
    while (n < stop_at) begin
      #1;
`ifdef PAL_FUSE_READBACK_EN
      if (pend >= 0) begin
        checks++;
        if (prog_dout !== pend_old) begin
          errors++;
          $display("FAIL readback bit %0d: got %b expected %b", pend, prog_dout, pend_old);
        end
      end
`endif
      pend = -1;
      if ($urandom_range(3) == 0) begin
        prog_valid = 1'b0;
        prog_din   = 1'($urandom_range(1));
      end else begin
        prog_valid = 1'b1;
        prog_din   = nm[n];
      end
      @(posedge clk);
      if (prog_valid) begin
        pend_old = mf[n];
        pend     = n;
        mf[n]    = nm[n];
        n++;
      end
    end
    #1;
`ifdef PAL_FUSE_READBACK_EN
    if (pend >= 0) begin
      checks++;
      if (prog_dout !== pend_old) begin
        errors++;
        $display("FAIL readback bit %0d: got %b expected %b", pend, prog_dout, pend_old);
      end
    end
`endif
    prog_valid = 1'b0;
    if (stop_at == F) begin
      checks++;
      if (prog_done !== 1'b1 || prog_busy !== 1'b0) begin
        errors++;
        $display("FAIL load_complete: got done=%b busy=%b expected done=1 busy=0", prog_done, prog_busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prog_en = 1'b0; prog_valid = 1'b0; prog_din = 1'b0; i = '0;
    for (int f = 0; f < F; f++) mf[f] = 1'b1;
    mq = '0;
    @(negedge clk);
    checks++;
    if ({o, prog_done, prog_busy, prog_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got o=%h done=%b busy=%b err=%b expected all 0", o, prog_done, prog_busy, prog_err);
    end
    rst_n = 1'b1;
    for (int v = 0; v < 256; v++) begin
      @(posedge clk); #1 i = 8'(v);
      @(negedge clk);
      checks++;
      if (o !== 8'h00 || prog_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_sweep i=%h: got o=%h done=%b expected o=00 done=0", i, o, prog_done);
      end
    end
  endtask

  task automatic test_registered();
    logic [NI-1:0] pat [3] = '{8'h01, 8'h00, 8'h00};
    logic          exp0 [3] = '{1'b0, 1'b1, 1'b0};
    map_blank();
    map_single(0, 0, 0);
    load(F);
    for (int c = 0; c < 3; c++) begin
      #1 i = pat[c];
      @(negedge clk);
      checks++;
      if (o[0] !== exp0[c] || o !== model_o(i)) begin
        errors++;
        $display("FAIL registered cyc%0d: got o=%h expected o[0]=%b o=%h", c, o, exp0[c], model_o(i));
      end
      @(posedge clk); step_model(i);
    end
  endtask

  task automatic test_toggle();
    logic exp1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    map_blank();
    map_single(1, 0, 2*9 + 1);
    load(F);
    for (int c = 0; c < 4; c++) begin
      #1 i = 8'($urandom);
      @(negedge clk);
      checks++;
      if (o[1] !== exp1[c] || o !== model_o(i)) begin
        errors++;
        $display("FAIL toggle cyc%0d: got o=%h expected o[1]=%b o=%h", c, o, exp1[c], model_o(i));
      end
      @(posedge clk); step_model(i);
    end
  endtask

  task automatic test_comb();
    map_blank();
    map_single(2, 0, 4);
    nm[mode_idx(2)]     = 1'b0;
    nm[mode_idx(2) + 1] = 1'b1;
    map_single(3, 0, 2*10);
    load(F);
    for (int c = 0; c < 8; c++) begin
      #1 i = 8'($urandom);
      @(negedge clk);
      checks++;
      if (o[2] !== ~i[2] || o !== model_o(i)) begin
        errors++;
        $display("FAIL comb cyc%0d: got o=%h expected o=%h", c, o, model_o(i));
      end
      #2 i = i ^ 8'h04;
      #1;
      checks++;
      if (o[2] !== ~i[2] || o !== model_o(i)) begin
        errors++;
        $display("FAIL comb_midcycle cyc%0d: got o=%h expected o=%h", c, o, model_o(i));
      end
      @(posedge clk); step_model(i);
    end
  endtask

  task automatic test_abort();
    map_random();
    load(100);
    prog_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (prog_err !== 1'b1 || prog_busy !== 1'b0 || prog_done !== 1'b0 || o !== 8'h00) begin
      errors++;
      $display("FAIL abort: got err=%b busy=%b done=%b o=%h expected err=1 busy=0 done=0 o=00",
               prog_err, prog_busy, prog_done, o);
    end
    prog_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (prog_err !== 1'b0 || prog_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_reload: got err=%b busy=%b expected err=0 busy=1", prog_err, prog_busy);
    end
    prog_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (prog_err !== 1'b1 || o !== 8'h00) begin
      errors++;
      $display("FAIL abort_again: got err=%b o=%h expected err=1 o=00", prog_err, o);
    end
  endtask

  task automatic test_reset_midload();
    map_random();
    load(500);
    rst_n = 1'b0;
    for (int f = 0; f < F; f++) mf[f] = 1'b1;
    mq = '0;
    #1;
    checks++;
    if ({o, prog_done, prog_busy, prog_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_midload: got o=%h done=%b busy=%b err=%b expected all 0", o, prog_done, prog_busy, prog_err);
    end
    @(negedge clk); rst_n = 1'b1; prog_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1 i = 8'($urandom);
      @(negedge clk);
      checks++;
      if (o !== 8'h00 || prog_done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_sweep i=%h: got o=%h done=%b expected o=00 done=0", i, o, prog_done);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      map_random();
      load(F);
      for (int c = 0; c < 50; c++) begin
        #1 i = 8'($urandom);
        prog_valid = 1'($urandom_range(1));
        prog_din   = 1'($urandom_range(1));
        @(negedge clk);
        checks++;
        if (o !== model_o(i)) begin
          errors++;
          $display("FAIL random map%0d cyc%0d i=%h: got o=%h expected o=%h", r, c, i, o, model_o(i));
        end
        @(posedge clk); step_model(i);
      end
      prog_valid = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_registered();
    test_toggle();
    test_comb();
    test_abort();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
